// File: rtl/error_gradient_gen.sv
// Output-end error generator: serial (prediction - target) gradient, valid/ack
// hand-off to the output layer, one-cycle training strobe and batch SSE loss.
//
// state   | meaning
// IDLE    | waiting for start; operands latched on acceptance
// COMPUTE | one gradient element and its square per cycle
// PRESENT | grad_valid high, waiting for grad_ack
// COMMIT  | training strobe, batch accumulation and loss report
module error_gradient_gen #(
  parameter int output_units = 2,
  parameter int batch_size   = 4,
  localparam int sfp_w       = 16,
  localparam int sfp_frac    = 8,
  localparam int sc_w        = $clog2(batch_size + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic signed [sfp_w-1:0] predictions    [output_units],
  input  logic signed [sfp_w-1:0] targets        [output_units],
  output logic                    busy,
  output logic signed [sfp_w-1:0] error_gradient [output_units],
  output logic                    grad_valid,
  input  logic                    grad_ack,
  output logic                    training,
  output logic signed [sfp_w-1:0] loss,
  output logic                    loss_valid,
  output logic [sc_w-1:0]         sample_count
);

  localparam int k_w     = (output_units > 1) ? $clog2(output_units) : 1;
  localparam int sfp_max = (1 << (sfp_w - 1)) - 1;
  localparam int sfp_min = -(1 << (sfp_w - 1));

  typedef enum logic [1:0] {IDLE, COMPUTE, PRESENT, COMMIT} state_t;

  // Signed fixed point, sfp_frac fractional bits; every operation saturates.
  function automatic logic signed [sfp_w-1:0] sfp_sat(input int x);
    if (x > sfp_max)      return sfp_w'(sfp_max);
    else if (x < sfp_min) return sfp_w'(sfp_min);
    else                  return x[sfp_w-1:0];
  endfunction

  function automatic logic signed [sfp_w-1:0] sfp_add(input logic signed [sfp_w-1:0] a,
                                                      input logic signed [sfp_w-1:0] b);
    return sfp_sat(int'(a) + int'(b));
  endfunction

  function automatic logic signed [sfp_w-1:0] sfp_sub(input logic signed [sfp_w-1:0] a,
                                                      input logic signed [sfp_w-1:0] b);
    return sfp_sat(int'(a) - int'(b));
  endfunction

  // Product rounded half-up before dropping the fractional bits.
  function automatic logic signed [sfp_w-1:0] sfp_mul(input logic signed [sfp_w-1:0] a,
                                                      input logic signed [sfp_w-1:0] b);
    int p;
    p = int'(a) * int'(b);
    return sfp_sat((p + (1 << (sfp_frac - 1))) >>> sfp_frac);
  endfunction

  state_t                  state;
  logic [k_w-1:0]          k;
  logic signed [sfp_w-1:0] pred_r [output_units];
  logic signed [sfp_w-1:0] tgt_r  [output_units];
  logic signed [sfp_w-1:0] sq_acc;
  logic signed [sfp_w-1:0] batch_acc;
  logic signed [sfp_w-1:0] d;
  logic signed [sfp_w-1:0] batch_sum;
  logic                    batch_close;

  always_comb begin
    d           = sfp_sub(pred_r[k], tgt_r[k]);
    batch_sum   = sfp_add(batch_acc, sq_acc);
    batch_close = (sample_count == sc_w'(batch_size - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      k            <= '0;
      sq_acc       <= '0;
      batch_acc    <= '0;
      busy         <= 1'b0;
      grad_valid   <= 1'b0;
      training     <= 1'b0;
      loss_valid   <= 1'b0;
      loss         <= '0;
      sample_count <= '0;
      for (int i = 0; i < output_units; i++) begin
        pred_r[i]         <= '0;
        tgt_r[i]          <= '0;
        error_gradient[i] <= '0;
      end
    end else begin
      training   <= 1'b0;
      loss_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < output_units; i++) begin
              pred_r[i] <= predictions[i];
              tgt_r[i]  <= targets[i];
            end
            k      <= '0;
            sq_acc <= '0;
            busy   <= 1'b1;
            state  <= COMPUTE;
          end
        end
        COMPUTE: begin
          error_gradient[k] <= d;
          sq_acc            <= sfp_add(sq_acc, sfp_mul(d, d));
          if (k == k_w'(output_units - 1)) begin
            grad_valid <= 1'b1;
            state      <= PRESENT;
          end else begin
            k <= k + k_w'(1);
          end
        end
        PRESENT: begin
          if (grad_ack) begin
            grad_valid <= 1'b0;
            training   <= 1'b1;
            state      <= COMMIT;
            // Batch bookkeeping lands with the strobe so loss/loss_valid align with training.
            if (batch_close) begin
              loss         <= batch_sum;
              loss_valid   <= 1'b1;
              batch_acc    <= '0;
              sample_count <= '0;
            end else begin
              batch_acc    <= batch_sum;
              sample_count <= sample_count + sc_w'(1);
            end
          end
        end
        COMMIT: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy       <= 1'b0;
          grad_valid <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/error_gradient_gen.md
# error_gradient_gen

Output-end error generator for the MLP training loop. It latches a sample's final-layer predictions and targets, then computes the per-output error gradient (prediction − target) serially, one output per cycle. It presents the gradient vector to the output-layer Perceptrons with a valid/ack handshake and issues the one-cycle `training` strobe that commits their weight update. It also accumulates the sum-of-squared-error over a batch and reports it when the batch closes.

## Interface
- `output_units`, default 2: number of output-layer neurons, ≥1.
- `batch_size`, default 4: samples per loss report, ≥1.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset; asynchronous assert, active-low, release synchronised externally.
- `start`  in  1  request to process a sample; accepted only in IDLE.
- `predictions`  in  sfp[output_units]  final-layer Perceptron `prediction` outputs.
- `targets`  in  sfp[output_units]  expected outputs.
- `busy`  out  1  high in every state except IDLE.
- `error_gradient`  out  sfp[output_units]  per-output gradient; drives `error_gradient_next_layer` of the output layer.
- `grad_valid`  out  1  `error_gradient` is complete and stable.
- `grad_ack`  in  1  consumer accepts the gradient.
- `training`  out  1  one-cycle strobe to Perceptron `training`.
- `loss`  out  sfp  batch sum of squared error; holds until the next batch closes.
- `loss_valid`  out  1  one-cycle strobe when `loss` is updated.
- `sample_count`  out  $clog2(batch_size+1)  samples completed in the current batch.

## Operation
- FSM states: IDLE, COMPUTE, PRESENT, COMMIT.
- IDLE: `start`=1 latches `predictions` and `targets` into internal registers, clears index k and `sq_acc`, then moves to COMPUTE. `start` is ignored in all other states.
- COMPUTE: one output per cycle for k = 0..output_units−1.
  - d = sfp_sub(pred[k], tgt[k]).
  - `error_gradient[k]` ← d.
  - `sq_acc` ← sfp_add(`sq_acc`, sfp_mul(d, d)).
  - After k = output_units−1, move to PRESENT.
- PRESENT: `grad_valid`=1. The FSM stays here until `grad_ack`=1, then moves to COMMIT.
- COMMIT: lasts one cycle.
  - `training`=1.
  - `batch_acc` ← sfp_add(`batch_acc`, `sq_acc`).
  - `sample_count` increments.
  - If the increment reaches `batch_size`: `loss` ← new `batch_acc`, `loss_valid`=1, `batch_acc` ← 0, `sample_count` ← 0.
  - Next state is IDLE.
- All arithmetic uses the FixedPoint sfp functions, so saturation and rounding are theirs. No extra guard bits are added.
- `error_gradient` holds its last value outside COMPUTE. It is overwritten one element at a time during the next COMPUTE.
- `grad_ack` has no effect outside PRESENT.
- Reset (`rst_n`=0, any state, asynchronous):
  - State returns to IDLE.
  - All outputs go to 0: `error_gradient`, `loss`, `grad_valid`, `training`, `loss_valid`, `busy`, `sample_count`.
  - `sq_acc` and `batch_acc` clear.
  - A sample in flight is discarded and no `training` strobe is issued.

## Timing
- Let `start` be accepted in cycle 0.
  - `busy` is high from cycle 1.
  - COMPUTE occupies cycles 1..output_units.
  - `grad_valid` rises in cycle output_units+1.
- `grad_ack` high in PRESENT cycle P gives `training`=1 in cycle P+1 (COMMIT). That is also the cycle `grad_valid` falls.
  - `loss_valid` coincides with that `training` cycle when the batch closes.
  - IDLE is reached in cycle P+2.
- Minimum sample period is output_units+3 cycles, with `grad_ack` tied high.
- `grad_valid`, `training`, `loss_valid` and `busy` are registered outputs, decoded from state.
- `error_gradient` is stable for the whole PRESENT and COMMIT interval.
- `grad_ack` arriving in the first PRESENT cycle is legal.

## Test plan
- **Reset values:** drive `rst_n` low mid-COMPUTE (k=1 of 2) → all outputs 0 immediately, without waiting for a clock edge. After release, IDLE with `sample_count`=0 and no `training` strobe.
- **Single sample, `output_units`=2:** `start`, predictions {0.75, 0.25}, targets {0.5, 0.5} → `error_gradient` = {0.25, −0.25}. `grad_valid` rises in cycle 3. `sq_acc` = 0.125.
- **Handshake stall:** hold `grad_ack` low for 5 cycles → `grad_valid` stays high with `error_gradient` unchanged. No `training` until the cycle after `grad_ack` goes high, and exactly one strobe then.
- **Batch close, `batch_size`=4:** four samples from the single-sample case → `sample_count` steps 1, 2, 3, 0. `loss_valid` pulses on the 4th `training` cycle with `loss` = 0.5. `loss` holds through the next batch.
- **Ignored inputs:**
  - `start` pulsed during COMPUTE and PRESENT → no restart; latched operands unchanged.
  - `grad_ack` in IDLE → no `training` strobe.
- **Back-to-back:** `start` in the IDLE cycle immediately after COMMIT, `grad_ack` tied high → samples complete every 5 cycles (`output_units`=2), with each `error_gradient` matching its own operands.
